// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, one-deep ROM request tracker and a
// DEPTH-entry prefetch FIFO of {pc, instr}. Optional FETCH_BYPASS_EN macro adds an empty-FIFO bypass.
module fetch_queue #(
  parameter int              PC_W     = 12,
  parameter int              INSTR_W  = 15,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 'o4000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic [PC_W-1:0]              rom_addr,
  output logic                         rom_req,
  input  logic [INSTR_W-1:0]           rom_data,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         fetch_hold,
  output logic                         out_valid,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [PC_W-1:0]              out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               inflight_q;
  logic [PC_W-1:0]    tag_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [PC_W-1:0]    last_pc_q, last_pc_d;
  logic [INSTR_W-1:0] last_instr_q, last_instr_d;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic               fifo_nonempty;
  logic               pop_fifo;
  logic               resp_vld;
  logic               bypass_vld;
  logic               bypass_take;
  logic               push;
  logic [CNT_W:0]     occupancy;
  logic               credit_ok;

  assign fifo_nonempty = (count_q != '0);
  assign pop_fifo      = fifo_nonempty & out_ready & ~redirect;
  assign resp_vld      = inflight_q & ~redirect;

`ifdef FETCH_BYPASS_EN
  // An arriving response skips the FIFO when nothing older is queued.
  assign bypass_vld  = ~fifo_nonempty & resp_vld;
  assign bypass_take = bypass_vld & out_ready;
`else
  assign bypass_vld  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = resp_vld & ~bypass_take;

  // Credits count queued entries plus the outstanding read, minus this cycle's pop.
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop_fifo);
  assign credit_ok = (occupancy < (CNT_W+1)'(DEPTH));

  assign rom_req  = reset_n & ~redirect & ~fetch_hold & credit_ok;
  assign rom_addr = pc_q;
  assign count    = count_q;

  always_comb begin
    out_valid = fifo_nonempty | bypass_vld;
    if (fifo_nonempty) begin
      out_pc    = pc_mem[rptr_q];
      out_instr = instr_mem[rptr_q];
    end else if (bypass_vld) begin
      out_pc    = tag_q;
      out_instr = rom_data;
    end else begin
      out_pc    = last_pc_q;
      out_instr = last_instr_q;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    last_pc_d    = last_pc_q;
    last_instr_d = last_instr_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (rom_req) pc_d = pc_q + PC_W'(1);
      if (push)    wptr_d = wptr_q + PTR_W'(1);
      if (pop_fifo) begin
        rptr_d       = rptr_q + PTR_W'(1);
        last_pc_d    = pc_mem[rptr_q];
        last_instr_d = instr_mem[rptr_q];
      end else if (bypass_take) begin
        last_pc_d    = tag_q;
        last_instr_d = rom_data;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= rom_req;
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      last_pc_q    <= last_pc_d;
      last_instr_q <= last_instr_d;
    end
  end

  // Data-only storage: the request tag and FIFO payload need no reset.
  always_ff @(posedge clock) begin
    if (rom_req) tag_q <= pc_q;
    if (push) begin
      pc_mem[wptr_q]    <= tag_q;
      instr_mem[wptr_q] <= rom_data;
    end
  end

  a_no_push_full: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push expected {pc, instr}
// into a queue; a negedge monitor pops and compares every accepted output.
module tb_fetch_queue;
  localparam int PC_W    = 12;
  localparam int INSTR_W = 15;
  localparam int DEPTH   = 4;

  logic               clock;
  logic               reset_n;
  logic [PC_W-1:0]    rom_addr;
  logic               rom_req;
  logic [INSTR_W-1:0] rom_data;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               fetch_hold;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_ready;
  logic [2:0]         count;

  int total = 0;
  int bad   = 0;
  logic [PC_W+INSTR_W-1:0] exp_q[$];

  fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(12'o4000)) dut (
    .clock(clock), .reset_n(reset_n), .rom_addr(rom_addr), .rom_req(rom_req),
    .rom_data(rom_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_hold(fetch_hold), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_ready(out_ready), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM model: data = pc ^ 15'h1234, one cycle after the request.
  always @(posedge clock) begin
    if (rom_req) rom_data <= {3'b000, rom_addr} ^ 15'h1234;
  end

  function automatic logic [PC_W+INSTR_W-1:0] mk(input logic [PC_W-1:0] pc);
    return {pc, {3'b000, pc} ^ 15'h1234};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_extra: got pc %0o, nothing expected", out_pc);
      end else begin
        logic [PC_W+INSTR_W-1:0] e;
        e = exp_q.pop_front();
        chk("mon_pc", 32'(out_pc), 32'(e[PC_W+INSTR_W-1:INSTR_W]));
        chk("mon_instr", 32'(out_instr), 32'(e[INSTR_W-1:0]));
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; redirect = 1'b0; fetch_hold = 1'b0; out_ready = 1'b0;
    redirect_pc = '0;
    @(negedge clock);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_req", 32'(rom_req), 0);
    repeat (2) @(posedge clock);
  endtask

  initial begin
    reset_n = 1'b0; redirect = 1'b0; fetch_hold = 1'b0; out_ready = 1'b0;
    redirect_pc = '0;

    // Phase 1: streaming from reset
    do_reset();
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_instr", 32'(out_instr), 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(12'o4000 + 12'(i)));
    for (int t = 0; t <= 10; t++) begin
      @(posedge clock); #1;
      if (t == 0) begin reset_n = 1'b1; out_ready = 1'b1; end
      fetch_hold = (t >= 8);
      @(negedge clock);
      if (t == 0) begin
        chk("p1_req0", 32'(rom_req), 1);
        chk("p1_addr0", 32'(rom_addr), 32'o4000);
      end
      if (t == 1) begin
        chk("p1_lat", 32'(out_valid), 0);
        chk("p1_addr1", 32'(rom_addr), 32'o4001);
      end
      if (t >= 2 && t <= 9) chk("p1_nogap", 32'(out_valid), 1);
      if (t == 2) chk("p1_first_pc", 32'(out_pc), 32'o4000);
      if (t == 10) chk("p1_empty", 32'(out_valid), 0);
    end
    chk("p1_drained", exp_q.size(), 0);

    // Phase 2: stall fills the FIFO, then drain and resume
    begin
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 6; i++) exp_q.push_back(mk(12'o4000 + 12'(i)));
      for (int t = 0; t <= 16; t++) begin
        @(posedge clock); #1;
        if (t == 0) reset_n = 1'b1;
        out_ready  = (t >= 10);
        fetch_hold = (t >= 12);
        @(negedge clock);
        if (t <= 9 && rom_req) pulses++;
        if (t == 5) chk("p2_count5", 32'(count), 4);
        if (t == 9) begin
          chk("p2_pulses", pulses, 4);
          chk("p2_count", 32'(count), 4);
          chk("p2_noreq", 32'(rom_req), 0);
          chk("p2_head", 32'(out_pc), 32'o4000);
        end
        if (t == 10) begin
          chk("p2_resume_req", 32'(rom_req), 1);
          chk("p2_resume_addr", 32'(rom_addr), 32'o4004);
        end
        if (t == 16) chk("p2_empty", 32'(out_valid), 0);
      end
      chk("p2_drained", exp_q.size(), 0);
    end

    // Phase 3: redirect with count=3 and a read in flight
    do_reset();
    exp_q.push_back(mk(12'o2000));
    exp_q.push_back(mk(12'o2001));
    for (int t = 0; t <= 9; t++) begin
      @(posedge clock); #1;
      if (t == 0) reset_n = 1'b1;
      redirect    = (t == 4);
      redirect_pc = 12'o2000;
      out_ready   = (t >= 5);
      fetch_hold  = (t >= 7);
      @(negedge clock);
      if (t == 4) begin
        chk("p3_pre_count", 32'(count), 3);
        chk("p3_redir_noreq", 32'(rom_req), 0);
      end
      if (t == 5) begin
        chk("p3_count", 32'(count), 0);
        chk("p3_valid", 32'(out_valid), 0);
        chk("p3_addr", 32'(rom_addr), 32'o2000);
        chk("p3_req", 32'(rom_req), 1);
      end
      if (t == 7) chk("p3_first_pc", 32'(out_pc), 32'o2000);
      if (t == 9) chk("p3_empty", 32'(out_valid), 0);
    end
    chk("p3_drained", exp_q.size(), 0);

    // Phase 4: redirect + pop with count=1, redirect under hold
    do_reset();
    exp_q.push_back(mk(12'o1000));
    for (int t = 0; t <= 7; t++) begin
      @(posedge clock); #1;
      if (t == 0) reset_n = 1'b1;
      fetch_hold  = (t != 0 && t != 4);
      out_ready   = (t >= 2);
      redirect    = (t == 2);
      redirect_pc = 12'o1000;
      @(negedge clock);
      if (t == 2) begin
        chk("p4_pre_count", 32'(count), 1);
        chk("p4_pre_pc", 32'(out_pc), 32'o4000);
      end
      if (t == 3) begin
        chk("p4_count", 32'(count), 0);
        chk("p4_valid", 32'(out_valid), 0);
        chk("p4_hold_req", 32'(rom_req), 0);
        chk("p4_addr", 32'(rom_addr), 32'o1000);
      end
      if (t == 4) chk("p4_req", 32'(rom_req), 1);
      if (t == 6) chk("p4_first_pc", 32'(out_pc), 32'o1000);
      if (t == 7) chk("p4_empty", 32'(out_valid), 0);
    end
    chk("p4_drained", exp_q.size(), 0);

    // Phase 5: PC wrap
    do_reset();
    exp_q.push_back(mk(12'hFFF));
    exp_q.push_back(mk(12'h000));
    for (int t = 0; t <= 5; t++) begin
      @(posedge clock); #1;
      if (t == 0) reset_n = 1'b1;
      redirect    = (t == 0);
      redirect_pc = 12'hFFF;
      fetch_hold  = (t == 0 || t >= 3);
      out_ready   = 1'b1;
      @(negedge clock);
      if (t == 1) chk("p5_addr_fff", 32'(rom_addr), 32'hFFF);
      if (t == 2) begin
        chk("p5_addr_wrap", 32'(rom_addr), 0);
        chk("p5_req_wrap", 32'(rom_req), 1);
      end
      if (t == 3) chk("p5_pc_fff", 32'(out_pc), 32'hFFF);
      if (t == 4) chk("p5_pc_000", 32'(out_pc), 0);
    end
    chk("p5_drained", exp_q.size(), 0);

    // Phase 6: asynchronous reset mid-stream
    do_reset();
    for (int t = 0; t <= 3; t++) begin
      @(posedge clock); #1;
      if (t == 0) reset_n = 1'b1;
      @(negedge clock);
    end
    chk("p6_pre_count", 32'(count), 2);
    #1 reset_n = 1'b0;
    #1;
    chk("p6_async_count", 32'(count), 0);
    chk("p6_async_valid", 32'(out_valid), 0);
    chk("p6_async_req", 32'(rom_req), 0);
    repeat (2) @(posedge clock);
    exp_q.push_back(mk(12'o4000));
    exp_q.push_back(mk(12'o4001));
    for (int t = 0; t <= 4; t++) begin
      @(posedge clock); #1;
      if (t == 0) begin reset_n = 1'b1; out_ready = 1'b1; end
      fetch_hold = (t >= 2);
      @(negedge clock);
      if (t == 0) chk("p6_restart_addr", 32'(rom_addr), 32'o4000);
      if (t == 2) chk("p6_first_pc", 32'(out_pc), 32'o4000);
      if (t == 4) chk("p6_empty", 32'(out_valid), 0);
    end
    chk("p6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end with a prefetch queue. It replaces the single PC register and fetch/decode register with a PC generator, a synchronous-ROM request tracker and a DEPTH-entry FIFO of {pc, instr} pairs. Decode consumes from the FIFO through a valid/ready handshake. Execute-stage branch redirects flush the FIFO and any in-flight ROM read.

Parameters:
PC_W, 12, PC / ROM word address width
INSTR_W, 15, instruction word width
DEPTH, 4, prefetch FIFO entries (power of two, >= 2)
RESET_PC, 'o4000, PC value after reset

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
rom_addr  out  PC_W  ROM fetch address (bank translation is external)
rom_req  out  1  fetch issued this cycle
rom_data  in  INSTR_W  ROM read data, valid the cycle after rom_req
redirect  in  1  branch taken in execute; flush and restart
redirect_pc  in  PC_W  new fetch PC when redirect=1
fetch_hold  in  1  suppress new requests (halt); does not flush
out_valid  out  1  FIFO head valid
out_instr  out  INSTR_W  head instruction
out_pc  out  PC_W  PC of head instruction
out_ready  in  1  decode accepts head (inverse of stall)
count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, any time, including with a read in flight): pc_f=RESET_PC, FIFO empty, count=0, out_valid=0, rom_req=0, in-flight flag=0. out_instr/out_pc reset to 0. First rom_req=1 can occur in the first cycle after reset_n deasserts.
- rom_addr = pc_f, combinational.
- Issue rule: rom_req = !redirect & !fetch_hold & (count + inflight < DEPTH), where the occupancy term includes the entry freed by a pop in the same cycle. On rom_req, pc_f <= pc_f+1, modulo 2^PC_W (wraps to 0, no error). inflight <= rom_req.
- Response: the cycle after rom_req, {pc_of_request, rom_data} is pushed at the end of that cycle unless a redirect occurs in that same cycle. A captured-PC register tags each request.
- Latency: with rom_req in cycle t, out_valid rises in cycle t+2 when the FIFO is empty. Steady-state throughput is 1 instr/cycle with out_ready held high.
- Pop: on out_valid & out_ready, read pointer advances. Pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged.
- Full: the credit rule guarantees no push to a full FIFO. An assertion flags any such push.
- Empty: out_valid=0. out_instr/out_pc hold the last head value (don't-care).
- Redirect (highest priority): at the edge, FIFO cleared, count=0, pc_f <= redirect_pc, inflight response discarded, no rom_req that cycle. A pop in the same cycle is ignored. A first request to redirect_pc issues the next cycle.
- fetch_hold: only blocks issue. An in-flight response is still pushed and the queue still drains.
- Simultaneous redirect and fetch_hold: redirect applies; fetching stays blocked until hold drops.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty and a response arrives (no redirect), it is presented combinationally the same cycle (out_valid=1, out_instr=rom_data, out_pc=tag). If out_ready=1 it is consumed and not written. Otherwise it is pushed. Latency from rom_req to out_valid becomes 1 cycle.
- Undefined: no bypass path; latency is 2 cycles as above.

Test Plan:
- Reset release, out_ready=1, ROM returns data=pc^15'h1234 -> rom_addr sequence 'o4000, 'o4001, ...; out_pc 'o4000 first valid at cycle 2 (cycle 1 with FETCH_BYPASS_EN); then one instr per cycle, no gaps.
- out_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 rom_req pulses; count=4; rom_req=0 thereafter; releasing out_ready drains 'o4000..'o4003 in order, and fetching resumes at 'o4004 with no skip or duplicate.
- Redirect to 'o2000 while count=3 and a read in flight -> next cycle count=0, out_valid=0; in-flight data discarded; next rom_addr='o2000; first out_pc='o2000.
- Redirect and pop in the same cycle with count=1 -> count=0, no stale entry ever appears on out_pc.
- pc_f=12'hFFF with PC_W=12 -> next rom_addr=12'h000; out_pc sequence FFF, 000.
- Assert reset_n low mid-stream with count=2 and inflight=1 -> outputs clear immediately (asynchronously); after release, fetch restarts at 'o4000 and no pre-reset data is emitted.
